// File: rtl/load_bin.sv
// Fetches one bin (clauses, var states, lvl states) from the bin BRAMs into the SAT engine.
// One counter walks LOAD and DRAIN, and every issue and capture point is decoded from it.
module load_bin #(
  parameter int NUM_CLAUSES_A_BIN     = 8,
  parameter int NUM_VARS_A_BIN        = 8,
  parameter int NUM_LVLS_A_BIN        = 8,
  parameter int WIDTH_CLAUSES         = NUM_VARS_A_BIN * 2,
  parameter int WIDTH_VAR             = 12,
  parameter int WIDTH_LVL             = 16,
  parameter int WIDTH_BIN_ID          = 10,
  parameter int WIDTH_VAR_STATES      = 30,
  parameter int WIDTH_LVL_STATES      = 30,
  parameter int ADDR_WIDTH_CLAUSES    = 9,
  parameter int ADDR_WIDTH_VAR        = 9,
  parameter int ADDR_WIDTH_VAR_STATES = 9,
  parameter int ADDR_WIDTH_LVL_STATES = 9
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start_load_i,
  input  logic [WIDTH_BIN_ID-1:0]                     load_bin_num_i,
  input  logic [WIDTH_LVL-1:0]                        base_lvl_i,
  output logic                                        apply_load_o,
  output logic                                        done_load_o,
  output logic [ADDR_WIDTH_CLAUSES-1:0]               ram_addr_c_o,
  input  logic [WIDTH_CLAUSES-1:0]                    ram_data_c_i,
  output logic [NUM_CLAUSES_A_BIN-1:0]                wr_carray_o,
  output logic [WIDTH_CLAUSES-1:0]                    clause_o,
  output logic [ADDR_WIDTH_VAR-1:0]                   ram_addr_v_o,
  input  logic [WIDTH_VAR-1:0]                        ram_data_v_i,
  output logic [ADDR_WIDTH_VAR_STATES-1:0]            ram_addr_vs_o,
  input  logic [WIDTH_VAR_STATES-1:0]                 ram_data_vs_i,
  output logic [ADDR_WIDTH_LVL_STATES-1:0]            ram_addr_ls_o,
  input  logic [WIDTH_LVL_STATES-1:0]                 ram_data_ls_i,
  output logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]  var_states_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]  lvl_states_o
);

  localparam int N_CV = (NUM_CLAUSES_A_BIN > NUM_VARS_A_BIN) ? NUM_CLAUSES_A_BIN : NUM_VARS_A_BIN;
  localparam int N    = (N_CV > NUM_LVLS_A_BIN) ? N_CV : NUM_LVLS_A_BIN;
  localparam int CW   = $clog2(N + 4);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            vz1;
  logic            vz2;
  logic            active;
  logic [31:0]     bin_m1;

  assign active = (state == LOAD) || (state == DRAIN);
  assign bin_m1 = 32'(load_bin_num_i) - 32'd1;

  // Clause data bypasses straight from the BRAM; only the strobe is registered.
  assign clause_o = (|wr_carray_o) ? ram_data_c_i : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      vz1           <= 1'b0;
      vz2           <= 1'b0;
      apply_load_o  <= 1'b0;
      done_load_o   <= 1'b0;
      ram_addr_c_o  <= '0;
      ram_addr_v_o  <= '0;
      ram_addr_vs_o <= '0;
      ram_addr_ls_o <= '0;
      wr_carray_o   <= '0;
      var_states_o  <= '0;
      lvl_states_o  <= '0;
    end else begin
      vz2 <= vz1;
      case (state)
        IDLE: begin
          if (start_load_i && (load_bin_num_i != '0)) begin
            state         <= LOAD;
            cnt           <= '0;
            apply_load_o  <= 1'b1;
            ram_addr_c_o  <= ADDR_WIDTH_CLAUSES'(bin_m1 * 32'(NUM_CLAUSES_A_BIN) + 32'd1);
            ram_addr_v_o  <= ADDR_WIDTH_VAR'(bin_m1 * 32'(NUM_VARS_A_BIN) + 32'd1);
            ram_addr_ls_o <= ADDR_WIDTH_LVL_STATES'(32'(base_lvl_i) + 32'd1);
            var_states_o  <= '0;
            lvl_states_o  <= '0;
          end
        end
        LOAD: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= DRAIN;
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N + 2)) begin
            state       <= DONE;
            done_load_o <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          done_load_o  <= 1'b0;
          apply_load_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (active) begin
        ram_addr_c_o  <= (cnt < CW'(NUM_CLAUSES_A_BIN - 1)) ? ram_addr_c_o + 1'b1 : '0;
        ram_addr_v_o  <= (cnt < CW'(NUM_VARS_A_BIN - 1))    ? ram_addr_v_o + 1'b1 : '0;
        ram_addr_ls_o <= (cnt < CW'(NUM_LVLS_A_BIN - 1))    ? ram_addr_ls_o + 1'b1 : '0;
        wr_carray_o   <= (cnt < CW'(NUM_CLAUSES_A_BIN)) ? (NUM_CLAUSES_A_BIN'(1) << cnt) : '0;
        // Var id for slot cnt-1 arrives now; it becomes the var-state address.
        if ((cnt >= CW'(1)) && (cnt <= CW'(NUM_VARS_A_BIN))) begin
          ram_addr_vs_o <= ADDR_WIDTH_VAR_STATES'(ram_data_v_i);
          vz1           <= (ram_data_v_i == '0);
        end else begin
          ram_addr_vs_o <= '0;
          vz1           <= 1'b0;
        end
        for (int s = 0; s < NUM_VARS_A_BIN; s++) begin
          if (cnt == CW'(s + 3))
            var_states_o[s*WIDTH_VAR_STATES +: WIDTH_VAR_STATES] <= vz2 ? '0 : ram_data_vs_i;
        end
        for (int s = 0; s < NUM_LVLS_A_BIN; s++) begin
          if (cnt == CW'(s + 1))
            lvl_states_o[s*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] <= ram_data_ls_i;
        end
      end else begin
        wr_carray_o   <= '0;
        ram_addr_vs_o <= '0;
        vz1           <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_bin.sv
// Directed bench for load_bin: BRAM models with 1-cycle latency, per-cycle expectations from the load timeline.
module tb_load_bin;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_load_i = 1'b0;
  logic [9:0]    load_bin_num_i = '0;
  logic [15:0]   base_lvl_i = '0;
  logic          apply_load_o, done_load_o;
  logic [8:0]    ram_addr_c_o, ram_addr_v_o, ram_addr_vs_o, ram_addr_ls_o;
  logic [15:0]   ram_data_c_i;
  logic [7:0]    wr_carray_o;
  logic [15:0]   clause_o;
  logic [11:0]   ram_data_v_i;
  logic [29:0]   ram_data_vs_i, ram_data_ls_i;
  logic [239:0]  var_states_o, lvl_states_o;

  logic [15:0] clause_mem [512];
  logic [11:0] var_mem    [512];
  logic [29:0] vs_mem     [512];
  logic [29:0] ls_mem     [512];

  int checks = 0;
  int failures = 0;

  load_bin dut (
    .clk(clk), .rst(rst), .start_load_i(start_load_i), .load_bin_num_i(load_bin_num_i),
    .base_lvl_i(base_lvl_i), .apply_load_o(apply_load_o), .done_load_o(done_load_o),
    .ram_addr_c_o(ram_addr_c_o), .ram_data_c_i(ram_data_c_i), .wr_carray_o(wr_carray_o),
    .clause_o(clause_o), .ram_addr_v_o(ram_addr_v_o), .ram_data_v_i(ram_data_v_i),
    .ram_addr_vs_o(ram_addr_vs_o), .ram_data_vs_i(ram_data_vs_i),
    .ram_addr_ls_o(ram_addr_ls_o), .ram_data_ls_i(ram_data_ls_i),
    .var_states_o(var_states_o), .lvl_states_o(lvl_states_o)
  );

  // clock/reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_data_c_i  <= clause_mem[ram_addr_c_o];
    ram_data_v_i  <= var_mem[ram_addr_v_o];
    ram_data_vs_i <= vs_mem[ram_addr_vs_o];
    ram_data_ls_i <= ls_mem[ram_addr_ls_o];
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input int bin, input int lvl, input bit hold);
    @(negedge clk);
    start_load_i   = 1'b1;
    load_bin_num_i = 10'(bin);
    base_lvl_i     = 16'(lvl);
    @(posedge clk);
    #1;
    if (!hold) start_load_i = 1'b0;
  endtask

  task automatic exp_states(input int bin, input int lvl, output logic [239:0] ev, output logic [239:0] el);
    int vb, lb, id;
    vb = ((bin - 1) * 8 + 1) % 512;
    lb = (lvl + 1) % 512;
    ev = '0;
    el = '0;
    for (int k = 0; k < 8; k++) begin
      id = int'(var_mem[(vb + k) % 512]);
      ev[k*30 +: 30] = (id == 0) ? 30'd0 : vs_mem[id % 512];
      el[k*30 +: 30] = ls_mem[(lb + k) % 512];
    end
  endtask

  // Walks cycles 0..12 after the start-sampling edge, checking every output against the timeline.
  task automatic check_load(input int bin, input int lvl);
    int cb, vb, lb, e_wr, e_vs;
    logic [239:0] ev, el;
    cb = ((bin - 1) * 8 + 1) % 512;
    vb = cb;
    lb = (lvl + 1) % 512;
    exp_states(bin, lvl, ev, el);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      e_wr = (c >= 1 && c <= 8) ? (1 << (c - 1)) : 0;
      e_vs = (c >= 2 && c <= 9) ? int'(var_mem[(vb + c - 2) % 512]) % 512 : 0;
      check($sformatf("addr_c b%0d c%0d", bin, c), 256'(ram_addr_c_o), 256'((c < 8) ? (cb + c) % 512 : 0));
      check($sformatf("addr_v b%0d c%0d", bin, c), 256'(ram_addr_v_o), 256'((c < 8) ? (vb + c) % 512 : 0));
      check($sformatf("addr_ls b%0d c%0d", bin, c), 256'(ram_addr_ls_o), 256'((c < 8) ? (lb + c) % 512 : 0));
      check($sformatf("wr_carray b%0d c%0d", bin, c), 256'(wr_carray_o), 256'(e_wr));
      check($sformatf("clause b%0d c%0d", bin, c), 256'(clause_o), 256'((e_wr != 0) ? (cb + c - 1) % 512 : 0));
      check($sformatf("addr_vs b%0d c%0d", bin, c), 256'(ram_addr_vs_o), 256'(e_vs));
      check($sformatf("done b%0d c%0d", bin, c), 256'(done_load_o), 256'(c == 11));
      check($sformatf("apply b%0d c%0d", bin, c), 256'(apply_load_o), 256'(c <= 11));
      if (c == 0) begin
        check($sformatf("var_clr b%0d", bin), 256'(var_states_o), 256'(0));
        check($sformatf("lvl_clr b%0d", bin), 256'(lvl_states_o), 256'(0));
      end
      if (c == 11) begin
        check($sformatf("var_states b%0d", bin), 256'(var_states_o), 256'(ev));
        check($sformatf("lvl_states b%0d", bin), 256'(lvl_states_o), 256'(el));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " apply"}, 256'(apply_load_o), 256'(0));
    check({tag, " done"}, 256'(done_load_o), 256'(0));
    check({tag, " addr_c"}, 256'(ram_addr_c_o), 256'(0));
    check({tag, " addr_v"}, 256'(ram_addr_v_o), 256'(0));
    check({tag, " addr_vs"}, 256'(ram_addr_vs_o), 256'(0));
    check({tag, " addr_ls"}, 256'(ram_addr_ls_o), 256'(0));
    check({tag, " wr_carray"}, 256'(wr_carray_o), 256'(0));
    check({tag, " clause"}, 256'(clause_o), 256'(0));
  endtask

  initial begin
    logic [239:0] ev, el;
    int done_cnt;
    for (int a = 0; a < 512; a++) begin
      clause_mem[a] = 16'(a);
      var_mem[a]    = (a % 4 == 2) ? 12'd0 : 12'((a * 3) % 512);
      vs_mem[a]     = 30'h0300_0000 + 30'(a * 7);
      ls_mem[a]     = 30'h0100_0000 + 30'(a * 5);
    end
    var_mem[9] = 12'd5;  var_mem[10] = 12'd0;  var_mem[11] = 12'd7;  var_mem[12] = 12'd20;
    var_mem[13] = 12'd0; var_mem[14] = 12'd33; var_mem[15] = 12'd40; var_mem[16] = 12'd0;
    vs_mem[5] = 30'hAAA;
    vs_mem[7] = 30'h123;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset var_states", 256'(var_states_o), 256'(0));
    check("reset lvl_states", 256'(lvl_states_o), 256'(0));
    rst = 1'b1;

    // Basic load, bin 2 base_lvl 3
    launch(2, 3, 1'b0);
    check_load(2, 3);
    check("slot0", 256'(var_states_o[29:0]), 256'(30'hAAA));
    check("slot1", 256'(var_states_o[59:30]), 256'(0));
    check("slot2", 256'(var_states_o[89:60]), 256'(30'h123));

    // Start held high: no restart mid-load, second load only after IDLE
    launch(3, 7, 1'b1);
    check_load(3, 7);
    @(posedge clk);
    #1 start_load_i = 1'b0;
    check_load(3, 7);

    // Bin 0 is rejected
    launch(0, 3, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_idle_outputs($sformatf("bin0 c%0d", c));
    end

    // Reset mid-load
    launch(2, 3, 1'b0);
    for (int c = 0; c <= 5; c++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    check("midrst var_states", 256'(var_states_o), 256'(0));
    check("midrst lvl_states", 256'(lvl_states_o), 256'(0));
    rst = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done_load_o) done_cnt++;
    end
    check("midrst no_done", 256'(done_cnt), 256'(0));
    launch(2, 3, 1'b0);
    check_load(2, 3);

    // Back-to-back: bin 1 values hold until next start clears them
    launch(1, 0, 1'b0);
    check_load(1, 0);
    exp_states(1, 0, ev, el);
    repeat (3) @(negedge clk);
    check("hold var_states", 256'(var_states_o), 256'(ev));
    check("hold lvl_states", 256'(lvl_states_o), 256'(el));
    launch(2, 5, 1'b0);
    check_load(2, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_bin.md
Name: load_bin

Overview:
- Fetches one bin from the bin BRAMs into the SAT engine, ahead of solving that bin.
- Streams the bin's clauses into the engine clause array with a one-hot write strobe.
- Resolves each local variable slot to its global variable id, reads that variable's state, and reads the level states starting above base_lvl_i.
- Presents the assembled var/lvl state vectors with a done pulse. This is the read-side counterpart of the bin write-back stage.

Parameters:
- NUM_CLAUSES_A_BIN, 8, clauses per bin
- NUM_VARS_A_BIN, 8, variable slots per bin
- NUM_LVLS_A_BIN, 8, level-state slots per bin
- WIDTH_CLAUSES, NUM_VARS_A_BIN*2, clause word width (2 bits per literal)
- WIDTH_VAR, 12, global variable id width
- WIDTH_LVL, 16, decision level width
- WIDTH_BIN_ID, 10, bin number width
- WIDTH_VAR_STATES, 30, one var state entry width
- WIDTH_LVL_STATES, 30, one lvl state entry width
- ADDR_WIDTH_CLAUSES / ADDR_WIDTH_VAR / ADDR_WIDTH_VAR_STATES / ADDR_WIDTH_LVL_STATES, 9 each, BRAM address widths

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- start_load_i  in  1  start pulse, sampled only in IDLE
- load_bin_num_i  in  WIDTH_BIN_ID  bin to load, 1-based; 0 is invalid
- base_lvl_i  in  WIDTH_LVL  current base decision level
- apply_load_o  out  1  high while state != IDLE; selects this block on the BRAM muxes
- done_load_o  out  1  one-cycle completion pulse
- ram_addr_c_o  out  ADDR_WIDTH_CLAUSES  clause BRAM read address
- ram_data_c_i  in  WIDTH_CLAUSES  clause BRAM read data
- wr_carray_o  out  NUM_CLAUSES_A_BIN  one-hot clause write strobe to the engine
- clause_o  out  WIDTH_CLAUSES  clause data to the engine
- ram_addr_v_o  out  ADDR_WIDTH_VAR  var-bin BRAM read address
- ram_data_v_i  in  WIDTH_VAR  global var id read back
- ram_addr_vs_o  out  ADDR_WIDTH_VAR_STATES  var-state BRAM read address
- ram_data_vs_i  in  WIDTH_VAR_STATES  var-state read data
- ram_addr_ls_o  out  ADDR_WIDTH_LVL_STATES  lvl-state BRAM read address
- ram_data_ls_i  in  WIDTH_LVL_STATES  lvl-state read data
- var_states_o  out  WIDTH_VAR_STATES*NUM_VARS_A_BIN  assembled var states; slot k at bits [k*W +: W]
- lvl_states_o  out  WIDTH_LVL_STATES*NUM_LVLS_A_BIN  assembled lvl states, same packing

Behaviour:
- Reset (rst==0 at a clock edge): state IDLE; counters 0. All outputs 0: addresses, wr_carray_o, clause_o, var_states_o, lvl_states_o, done_load_o, apply_load_o. Applies identically mid-operation; there is no partial done.
- All BRAMs have 1-cycle read latency: data is valid in the cycle after the address.
- States:
  - IDLE -> LOAD on start_load_i==1 && load_bin_num_i!=0.
  - LOAD lasts N = max(NUM_CLAUSES, NUM_VARS, NUM_LVLS) cycles, then DRAIN.
  - DRAIN lasts 3 cycles, then DONE.
  - DONE lasts 1 cycle, then IDLE.
  - start_load_i is ignored outside IDLE, including during DONE. A start with bin 0 is ignored.
- Cycle numbering: cycle 0 is the first cycle after the edge that samples start. Issue index k = 0..N-1 occurs in cycle k.
- Base addresses, latched at start:
  - cbase = (bin-1)*NUM_CLAUSES+1
  - vbase = (bin-1)*NUM_VARS+1
  - lbase = base_lvl_i+1
  - Arithmetic truncates to the address width; overflow is not flagged.
- Clauses:
  - For k < NUM_CLAUSES, ram_addr_c_o = cbase+k in cycle k.
  - In cycle k+1, wr_carray_o = 1<<k and clause_o = ram_data_c_i.
  - Otherwise wr_carray_o = 0 and clause_o = 0.
- Var states:
  - For k < NUM_VARS, ram_addr_v_o = vbase+k in cycle k.
  - ram_data_v_i is registered into ram_addr_vs_o, valid in cycle k+2.
  - ram_data_vs_i is captured into slot k at the end of cycle k+3.
  - If the var id read is 0 (empty slot), slot k is captured as all-zeros regardless of ram_data_vs_i.
- Lvl states:
  - For k < NUM_LVLS, ram_addr_ls_o = lbase+k in cycle k.
  - ram_data_ls_i is captured into slot k at the end of cycle k+1.
- Address outputs return to 0 when not issuing.
- var_states_o and lvl_states_o are cleared at start and hold their values after DONE until the next accepted start.
- Timing with defaults (N=8):
  - clause strobes in cycles 1..8
  - last var capture at the end of cycle 10
  - done_load_o high in cycle 11 only
  - apply_load_o high in cycles 0..11

Test Plan:
- Reset then bin=2, base_lvl=3 (defaults) -> ram_addr_c_o 9..16 in cycles 0..7; wr_carray_o 0x01..0x80 in cycles 1..8 carrying clause words 9..16; ram_addr_ls_o 4..11; done_load_o only in cycle 11; apply_load_o cycles 0..11.
- Var bin words 9..16 = ids 5,0,7,..., var-state RAM[5]=0xAAA, RAM[7]=0x123 -> ram_addr_vs_o=5 in cycle 2; var_states_o slot0=0xAAA, slot1=0, slot2=0x123 at done.
- start_load_i held high through the whole load, bin=3 -> no restart; second load (cbase 17) begins only when start is sampled after return to IDLE.
- start with load_bin_num_i=0 -> stays IDLE, apply_load_o and done_load_o remain 0.
- rst=0 in cycle 5 -> next cycle all outputs 0 and state IDLE; no done pulse; a new start then completes normally.
- Back-to-back loads bin=1 then bin=2 -> var_states_o/lvl_states_o hold bin1 values until the second start, are cleared, then show bin2 values at the second done.
